// File: rtl/serial_logic_pkg.sv
// Shared types and constants for the bit-serial logic sequencer.
package serial_logic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam int DEF_W = 8;

endpackage

// File: rtl/serial_logic_seq_bit_counter.sv
// Bit-position counter: sync clear, enable, saturates at terminal count W-1.
module bit_counter #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_logic_seq.sv
// Bit-serial operand sequencer feeding an external 1-bit logic cell, LSB first.
// Optional zero-result flag port enabled by SERIAL_LOGIC_ZERO_FLAG_EN.
module serial_logic_seq
    import serial_logic_pkg::*;
#(
    parameter  int W  = DEF_W,
    localparam int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [1:0]   sel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    output logic         zero,
`endif
    output logic         cl_a,
    output logic         cl_b,
    output logic [1:0]   cl_s,
    input  logic         cl_out
);

    state_t         state;
    logic [W-1:0]   a_sh, b_sh;
    logic [1:0]     sel_q;
    logic [CW-1:0]  cnt;
    logic           tc;
    logic           accept;

    assign accept = start && (state != ST_RUN);

    bit_counter #(.W(W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == ST_RUN),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Cell inputs are gated so the cell sees zeros whenever no run is active.
    assign cl_a = (state == ST_RUN) & a_sh[0];
    assign cl_b = (state == ST_RUN) & b_sh[0];
    assign cl_s = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sel_q  <= OP_AND;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    result <= {cl_out, result[W-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
                    zero   <= zero & ~cl_out;
`endif
                    if (tc) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= op_a;
                        b_sh   <= op_b;
                        sel_q  <= sel;
                        result <= '0;
                        state  <= ST_RUN;
                        busy   <= 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
                        // Clear-then-set collapse into one edge: start the AND-accumulation at 1.
                        zero   <= 1'b1;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_seq.sv
// Self-checking bench for serial_logic_seq: vector table, random runs, multi-cycle corners.
module tb_serial_logic_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic [1:0]   sel = 2'b00;
    logic         busy, done, cl_a, cl_b, cl_out;
    logic [W-1:0] result;
    logic [1:0]   cl_s;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic         zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_logic_seq #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .cl_a   (cl_a),
        .cl_b   (cl_b),
        .cl_s   (cl_s),
        .cl_out (cl_out)
    );

    // The external 1-bit logic cell.
    always_comb begin
        case (cl_s)
            2'b00:   cl_out = cl_a & cl_b;
            2'b01:   cl_out = cl_a | cl_b;
            2'b10:   cl_out = cl_a ^ cl_b;
            default: cl_out = ~cl_a;
        endcase
    end

    // Whole-word reference for the bitwise operation.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 with DUT idle; leaves at posedge+1 after the capture edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        op_a  = a;
        op_b  = b;
        sel   = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_capture", 32'(busy), 32'd1);
        chk("cl_s_run", 32'(cl_s), 32'(s));
        chk("cl_a_bit0", 32'(cl_a), 32'(a[0]));
        chk("cl_b_bit0", 32'(cl_b), 32'(b[0]));
    endtask

    // Counts edges until done; drop_start releases start after the first edge.
    task automatic wait_done(input bit drop_start, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(posedge clk); #1;
            if (drop_start) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] s, input logic [W-1:0] exp);
        int lat, bc;
        launch(a, b, s);
        wait_done(1'b0, lat, bc);
        chk({nm, "_latency"}, 32'(lat), 32'(W));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(W - 1));
        chk({nm, "_result"}, 32'(result), 32'(exp));
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk({nm, "_zero"}, 32'(zero), 32'(exp == '0));
`endif
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_result_held"}, 32'(result), 32'(exp));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   s;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, nodone;
        logic [W-1:0] ra, rb;
        logic [1:0]   rs;

        tbl[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30};
        tbl[1] = '{8'hA5, 8'h0F, 2'b01, 8'hAF};
        tbl[2] = '{8'hFF, 8'h0F, 2'b10, 8'hF0};
        tbl[3] = '{8'h5A, 8'hFF, 2'b11, 8'hA5};

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cl_a", 32'(cl_a), 32'd0);
        chk("rst_cl_b", 32'(cl_b), 32'd0);
        chk("rst_cl_s", 32'(cl_s), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 2'($urandom_range(0, 3));
            run_check($sformatf("rnd%0d", i), ra, rb, rs, ref_op(ra, rb, rs));
        end

        // Start held through a run with new operands: ignored while busy, taken in DONE.
        op_a = 8'hF0; op_b = 8'h3C; sel = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        op_a = 8'hA5; op_b = 8'h0F; sel = 2'b01;
        wait_done(1'b0, lat, bc);
        chk("held_latency", 32'(lat), 32'(W));
        chk("held_result1", 32'(result), 32'h30);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_restart_busy", 32'(busy), 32'd1);
        chk("held_restart_done", 32'(done), 32'd0);
        wait_done(1'b0, lat, bc);
        chk("held_latency2", 32'(lat), 32'(W));
        chk("held_result2", 32'(result), 32'hAF);
        @(posedge clk); #1;

        // Back-to-back: start issued during the DONE cycle.
        launch(8'hF0, 8'h3C, 2'b00);
        wait_done(1'b0, lat, bc);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_result", 32'(result), 32'h30);
        op_a = 8'h00; op_b = 8'hFF; sel = 2'b10; start = 1'b1;
        wait_done(1'b1, lat, bc);
        chk("b2b_spacing", 32'(lat), 32'(W + 1));
        chk("b2b_second_result", 32'(result), 32'hFF);
        @(posedge clk); #1;

        // Reset during RUN cycle 4: abort with no done pulse.
        launch(8'hFF, 8'hFF, 2'b01);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_cl_a", 32'(cl_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        nodone = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (done || busy) nodone++;
        end
        chk("midrst_no_done", 32'(nodone), 32'd0);
        run_check("post_rst", 8'h3C, 8'h66, 2'b10, 8'h5A);

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        run_check("zero_and", 8'hF0, 8'h0F, 2'b00, 8'h00);
        chk("zero_and_flag", 32'(zero), 32'd1);
        run_check("zero_or", 8'h01, 8'h00, 2'b01, 8'h01);
        chk("zero_or_flag", 32'(zero), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
